// File: rtl/cellrv32_package.sv
`default_nettype none
// ============================================================================
// Package     : cellrv32_package
// Description : Shared constants and helpers for the cellrv32 processor.
//               Holds the bus keeper register address, its size and the bit
//               positions of its status fields.
// Revision    : 1.0 - initial release
// ============================================================================
package cellrv32_package;

    // Bus keeper status register: one 32-bit word.
    localparam logic [31:0] buskeeper_base_c = 32'hFFFF_FF7C;
    localparam int          buskeeper_size_c = 4;

    // Status register fields.
    localparam int buskeeper_err_type_c = 0;   // 0 = device error, 1 = timeout
    localparam int buskeeper_err_flag_c = 31;  // sticky error flag

    // Number of address bits covered by a region of 'size' bytes
    // (ceil(log2(size))). Used to derive the low bound of the address decode.
    function automatic int index_size_f(input int size);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (size > (1 << i)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cellrv32_bus_keeper.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_bus_keeper
// Description : Data-bus transfer monitor. Watches every CPU request and
//               raises a one-cycle bus error if no responder answers within
//               TIMEOUT cycles. Records the cause of the last error in a
//               memory-mapped status register (bit 31 sticky flag, bit 0
//               cause: 0 = device error, 1 = timeout).
// Revision    : 1.0 - initial release
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   synchronous active-high reset
//   addr_i    in   [31:0] CPU address, valid in the request cycle
//   rden_i    in   read request strobe (single cycle)
//   wren_i    in   write request strobe (single cycle)
//   bus_ack_i in   OR of all responder acks (includes ack_o)
//   bus_err_i in   OR of all responder errors (excludes err_o)
//   data_o    out  [31:0] status register read data, zero when not reading
//   ack_o     out  acknowledge for accesses to the status register
//   err_o     out  timeout error pulse toward the CPU
// ============================================================================
module cellrv32_bus_keeper
    import cellrv32_package::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam int              c_lo       = index_size_f(buskeeper_size_c);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_flag;
    logic             r_err_type;
    logic [31:0]      r_data;
    logic             r_ack;
    logic             r_err;

    logic        w_hit;
    logic        w_own_rd;
    logic        w_own_wr;
    logic        w_dev_err;
    logic        w_timeout;
    logic [31:0] w_status;
    logic        w_unused;

    // Byte offset bits inside the single status word are don't-care.
    assign w_unused = ^addr_i[c_lo-1:0];

    assign w_hit    = (addr_i[31:c_lo] == buskeeper_base_c[31:c_lo]);
    assign w_own_rd = rden_i & w_hit;
    assign w_own_wr = wren_i & w_hit;

    // Error events recorded while a transfer is pending. A device error has
    // priority over an ack, an ack has priority over the timeout expiry.
    assign w_dev_err = (r_state == PENDING) & bus_err_i;
    assign w_timeout = (r_state == PENDING) & ~bus_err_i & ~bus_ack_i &
                       (r_cnt == c_cnt_last);

    always_comb begin
        w_status                       = '0;
        w_status[buskeeper_err_flag_c] = r_err_flag;
        w_status[buskeeper_err_type_c] = r_err_type;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
            r_err_type <= 1'b0;
            r_data     <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_timeout;

            // An own-register access can only collide with the timeout pulse
            // if it was issued illegally during a pending transfer; the error
            // pulse takes the cycle so err_o and ack_o never overlap.
            r_ack  <= (w_own_rd | w_own_wr) & ~w_timeout;
            r_data <= (w_own_rd & ~w_timeout) ? w_status : 32'h0;

            case (r_state)
                IDLE: begin
                    if (rden_i | wren_i) begin
                        r_state <= PENDING;
                        r_cnt   <= '0;
                    end
                end
                PENDING: begin
                    // New strobes here are protocol violations and ignored.
                    if (bus_err_i | bus_ack_i) begin
                        r_state <= IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // A new error event beats a simultaneous clearing write.
            if (w_dev_err) begin
                r_err_flag <= 1'b1;
                r_err_type <= 1'b0;
            end else if (w_timeout) begin
                r_err_flag <= 1'b1;
                r_err_type <= 1'b1;
            end else if (w_own_wr) begin
                r_err_flag <= 1'b0;
                r_err_type <= 1'b0;
            end
        end
    end

    assign data_o = r_data;
    assign ack_o  = r_ack;
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_bus_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_cellrv32_bus_keeper
// Description : Directed self-checking bench for cellrv32_bus_keeper with
//               TIMEOUT = 15. The responder ack is modelled as the bench's
//               own ack OR-ed with the keeper's ack_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cellrv32_bus_keeper;

    localparam int          TIMEOUT = 15;
    localparam logic [31:0] c_base  = 32'hFFFF_FF7C;
    localparam logic [31:0] c_ext   = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic [31:0] r_addr;
    logic        r_rden;
    logic        r_wren;
    logic        r_ack_ext;
    logic        r_err_ext;
    logic        w_bus_ack;
    logic [31:0] w_data;
    logic        w_ack;
    logic        w_err;

    int n_checks;
    int n_errors;

    assign w_bus_ack = r_ack_ext | w_ack;

    cellrv32_bus_keeper #(
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (r_addr),
        .rden_i   (r_rden),
        .wren_i   (r_wren),
        .bus_ack_i(w_bus_ack),
        .bus_err_i(r_err_ext),
        .data_o   (w_data),
        .ack_o    (w_ack),
        .err_o    (w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle strobe; returns in cycle 1 of the transfer.
    task automatic req(input logic rd, input logic wr, input logic [31:0] addr);
        r_addr = addr;
        r_rden = rd;
        r_wren = wr;
        cycle();
        r_rden = 1'b0;
        r_wren = 1'b0;
    endtask

    task automatic rd_status(input string tag, input logic [31:0] exp);
        req(1'b1, 1'b0, c_base);
        check_val({tag, "_ack"}, {31'h0, w_ack}, 32'h1);
        check_val({tag, "_data"}, w_data, exp);
        check_val({tag, "_err"}, {31'h0, w_err}, 32'h0);
        cycle();
        check_val({tag, "_idle"}, {w_data[31:1], w_ack}, 32'h0);
    endtask

    task automatic wr_clear(input string tag);
        req(1'b0, 1'b1, c_base);
        check_val({tag, "_ack"}, {31'h0, w_ack}, 32'h1);
        check_val({tag, "_err"}, {31'h0, w_err}, 32'h0);
        cycle();
    endtask

    // Run n cycles and count any err_o seen.
    task automatic quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (w_err) seen++;
            cycle();
        end
        check_val(tag, seen, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        r_addr    = '0;
        r_rden    = 1'b0;
        r_wren    = 1'b0;
        r_ack_ext = 1'b0;
        r_err_ext = 1'b0;
        cycle();
        cycle();
        check_val("rst_data", w_data, 32'h0);
        check_val("rst_ack", {31'h0, w_ack}, 32'h0);
        check_val("rst_err", {31'h0, w_err}, 32'h0);
        rst = 1'b0;
        cycle();
        rd_status("rst_status", 32'h0);

        // Responder acks in cycle 1.
        req(1'b1, 1'b0, c_ext);
        r_ack_ext = 1'b1;
        cycle();
        r_ack_ext = 1'b0;
        quiet("ack1_no_err", 20);
        rd_status("ack1_status", 32'h0);

        // No responder: pulse in cycle 16 only.
        req(1'b1, 1'b0, c_ext);
        for (int k = 1; k <= 20; k++) begin
            check_val($sformatf("to_pulse_c%0d", k), {31'h0, w_err}, {31'h0, (k == 16)});
            if (k == 16) check_val("to_no_ack", {31'h0, w_ack}, 32'h0);
            cycle();
        end
        rd_status("to_status", 32'h8000_0001);
        wr_clear("to_clr");
        rd_status("to_cleared", 32'h0);

        // Ack exactly in cycle 15 wins over expiry.
        req(1'b0, 1'b1, c_ext);
        for (int i = 0; i < 14; i++) cycle();
        r_ack_ext = 1'b1;
        cycle();
        r_ack_ext = 1'b0;
        quiet("ack15_no_err", 20);
        rd_status("ack15_status", 32'h0);

        // Ack in cycle 16 is too late.
        req(1'b1, 1'b0, c_ext);
        for (int i = 0; i < 15; i++) cycle();
        check_val("ack16_pulse", {31'h0, w_err}, 32'h1);
        r_ack_ext = 1'b1;
        cycle();
        r_ack_ext = 1'b0;
        check_val("ack16_single", {31'h0, w_err}, 32'h0);
        rd_status("ack16_status", 32'h8000_0001);
        wr_clear("ack16_clr");

        // Device error together with ack in cycle 2.
        req(1'b1, 1'b0, c_ext);
        cycle();
        r_ack_ext = 1'b1;
        r_err_ext = 1'b1;
        cycle();
        r_ack_ext = 1'b0;
        r_err_ext = 1'b0;
        quiet("deverr_no_err", 20);
        rd_status("deverr_status", 32'h8000_0000);
        wr_clear("deverr_clr");
        rd_status("deverr_cleared", 32'h0);

        // Clearing write in the same cycle as the timeout expiry.
        req(1'b1, 1'b0, c_ext);
        for (int i = 0; i < 14; i++) cycle();
        r_addr = c_base;
        r_wren = 1'b1;
        cycle();
        r_wren = 1'b0;
        check_val("clrto_pulse", {31'h0, w_err}, 32'h1);
        check_val("clrto_no_ack", {31'h0, w_ack}, 32'h0);
        cycle();
        rd_status("clrto_status", 32'h8000_0001);
        wr_clear("clrto_clr");

        // Clearing write in the same cycle as a device error.
        req(1'b1, 1'b0, c_ext);
        r_addr    = c_base;
        r_wren    = 1'b1;
        r_err_ext = 1'b1;
        cycle();
        r_wren    = 1'b0;
        r_err_ext = 1'b0;
        check_val("clrde_ack", {31'h0, w_ack}, 32'h1);
        check_val("clrde_err", {31'h0, w_err}, 32'h0);
        cycle();
        rd_status("clrde_status", 32'h8000_0000);
        wr_clear("clrde_clr");

        // Reset in cycle 5 of a pending transfer.
        req(1'b1, 1'b0, c_ext);
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("midrst_data", w_data, 32'h0);
        check_val("midrst_ack", {31'h0, w_ack}, 32'h0);
        check_val("midrst_err", {31'h0, w_err}, 32'h0);
        quiet("midrst_no_err", 20);
        rd_status("midrst_status", 32'h0);

        // Next request is normal; a stray strobe in cycle 5 must not restart.
        req(1'b1, 1'b0, c_ext);
        for (int k = 1; k <= 17; k++) begin
            if (k == 5) begin
                r_rden = 1'b1;
            end
            if (k >= 14) begin
                check_val($sformatf("post_c%0d", k), {31'h0, w_err}, {31'h0, (k == 16)});
            end
            cycle();
            r_rden = 1'b0;
        end
        rd_status("post_status", 32'h8000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
